// File: rtl/wasm_arb_pkg.sv
// Shared types for the wasm memory arbiter.
// Optional build macro: WASM_ARB_ROUND_ROBIN_EN.
package wasm_arb_pkg;

   typedef enum logic {
      IDLE,
      WAIT
   } arb_state_t;

   typedef enum logic {
      ID_FETCH = 1'b0,
      ID_DATA  = 1'b1
   } arb_id_t;

   localparam int CNT_W = 3;

endpackage

// File: rtl/wasm_arb_pick.sv
// Winner selection between fetch and data requesters.
// WASM_ARB_ROUND_ROBIN_EN selects round-robin, else fixed fetch priority.
module wasm_arb_pick
   import wasm_arb_pkg::*;
(
   input  logic    req0,
   input  logic    req1,
   input  arb_id_t last_id,
   output logic    any_req,
   output arb_id_t win_id
);

`ifdef WASM_ARB_ROUND_ROBIN_EN
   always_comb begin
      any_req = req0 | req1;
      win_id  = ID_FETCH;
      unique case (1'b1)
         (req0 && req1):
            win_id = (last_id == ID_FETCH) ? ID_DATA : ID_FETCH;
         (!req0 && req1):
            win_id = ID_DATA;
         default:
            win_id = ID_FETCH;
      endcase
   end
`else
   logic unused_last;
   assign unused_last = last_id;

   always_comb begin
      any_req = req0 | req1;
      win_id  = (!req0 && req1) ? ID_DATA : ID_FETCH;
   end
`endif

endmodule

// File: rtl/wasm_mem_arbiter.sv
// Two-requester arbiter in front of the genrom read port.
// Policy macro: WASM_ARB_ROUND_ROBIN_EN (defined: round-robin, else r0 first).
module wasm_mem_arbiter
   import wasm_arb_pkg::*;
#(
   parameter int MEM_ADDR  = 5,
   parameter int MEM_EXTRA = 4,
   parameter int MEM_LAT   = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          r0_req,
   input  logic [MEM_ADDR:0]             r0_addr,
   input  logic [MEM_EXTRA-1:0]          r0_extra,
   input  logic [MEM_ADDR:0]             r0_lower_bound,
   input  logic [MEM_ADDR:0]             r0_upper_bound,
   input  logic                          r1_req,
   input  logic [MEM_ADDR:0]             r1_addr,
   input  logic [MEM_EXTRA-1:0]          r1_extra,
   input  logic [MEM_ADDR:0]             r1_lower_bound,
   input  logic [MEM_ADDR:0]             r1_upper_bound,
   output logic                          r0_gnt,
   output logic                          r1_gnt,
   output logic                          r0_rvalid,
   output logic                          r1_rvalid,
   output logic [(2**MEM_EXTRA)*8-1:0]   rdata,
   output logic                          rerr,
   output logic [MEM_ADDR:0]             mem_addr,
   output logic [MEM_EXTRA-1:0]          mem_extra,
   output logic [MEM_ADDR:0]             mem_lower_bound,
   output logic [MEM_ADDR:0]             mem_upper_bound,
   input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
   input  logic                          mem_error
);

   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   arb_id_t          id_q;
   arb_id_t          win_id;
   logic             any_req;
   logic             gnt_en;
   logic             rsp_cyc;
   logic             load_rsp;

   wasm_arb_pick u_pick (
      .req0    (r0_req),
      .req1    (r1_req),
      .last_id (id_q),
      .any_req (any_req),
      .win_id  (win_id)
   );

   assign rsp_cyc  = (state_q == WAIT) && (cnt_q == '0);
   assign load_rsp = (state_q == WAIT) && (cnt_q == CNT_W'(1));
   assign gnt_en   = any_req && ((state_q == IDLE) || rsp_cyc);
   assign r0_gnt   = gnt_en && (win_id == ID_FETCH);
   assign r1_gnt   = gnt_en && (win_id == ID_DATA);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_en) begin
               state_d = WAIT;
               cnt_d   = LAT_C;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (gnt_en) begin
               cnt_d = LAT_C;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // id_q doubles as the rr pointer; resetting to ID_DATA lets r0 win first
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id_q            <= ID_DATA;
         mem_addr        <= '0;
         mem_extra       <= '0;
         mem_lower_bound <= '0;
         mem_upper_bound <= '1;
         r0_rvalid       <= 1'b0;
         r1_rvalid       <= 1'b0;
         rdata           <= '0;
         rerr            <= 1'b0;
      end else begin
         if (gnt_en) begin
            id_q <= win_id;
            if (win_id == ID_DATA) begin
               mem_addr        <= r1_addr;
               mem_extra       <= r1_extra;
               mem_lower_bound <= r1_lower_bound;
               mem_upper_bound <= r1_upper_bound;
            end else begin
               mem_addr        <= r0_addr;
               mem_extra       <= r0_extra;
               mem_lower_bound <= r0_lower_bound;
               mem_upper_bound <= r0_upper_bound;
            end
         end
         r0_rvalid <= load_rsp && (id_q == ID_FETCH);
         r1_rvalid <= load_rsp && (id_q == ID_DATA);
         if (load_rsp) begin
            rdata <= mem_data;
            rerr  <= mem_error;
         end
      end
   end

endmodule
